dr_adder_sched: RTL and testbench

Synchronous sequencer and two-port arbiter for the dual-rail 4-bit ripple adder with completion detection. It accepts binary add requests from two requesters and grants them round-robin. It encodes each granted request into dual-rail code words, runs the adder through one data phase and one spacer (return-to-zero) phase using its `go`/`done` handshake, and returns the binary sum. A timeout recovers the adder by resetting it. It is the clocked front end for every instance of the asynchronous adder.

---
 rtl/dr_adder_sched.sv | 118 +++++++++++
 tb/tb_dr_adder_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_adder_sched.sv
// dr_adder_sched: round-robin front end running a dual-rail adder through data and spacer phases
module dr_adder_sched #(
    parameter int W = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W:0]   rsp_sum,
    output logic         rsp_err,
    output logic [W-1:0] a_1,
    output logic [W-1:0] a_0,
    output logic [W-1:0] b_1,
    output logic [W-1:0] b_0,
    input  logic [W:0]   s_1,
    input  logic [W:0]   s_0,
    output logic         go,
    input  logic         done,
    output logic         adder_reset
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, DATA, SPACER, RECOVER, RESP} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic [W-1:0] op_a, op_b, a_n, b_n;
    logic done_s, timeout, pick, take, rr, rst_d;

    assign done_s = sync[SYNC_STAGES-1];
    assign timeout = cnt == CW'(TIMEOUT - 1);
    assign pick = (req0_valid && req1_valid) ? rr : req1_valid;
    assign take = state == IDLE && !reset && (req0_valid || req1_valid);
    assign req0_ready = take && !pick;
    assign req1_ready = take && pick;
    assign a_n = take ? (pick ? req1_a : req0_a) : op_a;
    assign b_n = take ? (pick ? req1_b : req0_b) : op_b;

    // Bring the asynchronous completion flag into the clock domain
    always_ff @(posedge clk) begin
        if (reset)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], done};
    end

    // Phase sequencing: leave on completion edges, fall back to recovery on timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = take ? DATA : IDLE;
            DATA:    nxt = done_s ? SPACER : timeout ? RECOVER : DATA;
            SPACER:  nxt = !done_s ? RESP : timeout ? RECOVER : SPACER;
            RECOVER: nxt = ((cnt != '0 && !done_s) || timeout) ? RESP : RECOVER;
            RESP:    nxt = rsp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    // State, operands, rails/go registered from the next state, and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr <= 1'b0;
            cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            a_1 <= '0;
            a_0 <= '0;
            b_1 <= '0;
            b_0 <= '0;
            go <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
            rst_d <= 1'b1;
            adder_reset <= 1'b1;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? '0 : cnt + 1'b1;
            op_a <= a_n;
            op_b <= b_n;
            a_1 <= (nxt == DATA) ? a_n : '0;
            a_0 <= (nxt == DATA) ? ~a_n : '0;
            b_1 <= (nxt == DATA) ? b_n : '0;
            b_0 <= (nxt == DATA) ? ~b_n : '0;
            go <= nxt == DATA;
            rsp_valid <= nxt == RESP;
            rst_d <= 1'b0;
            adder_reset <= rst_d || nxt == RECOVER;
            if (take) begin
                rr <= !pick;
                rsp_id <= pick;
                rsp_sum <= '0;
                rsp_err <= 1'b0;
            end
            if (state == DATA && done_s) begin
                rsp_sum <= s_1;
                rsp_err <= (s_1 ^ s_0) != '1;
            end else if (nxt == RECOVER) begin
                rsp_err <= 1'b1;
                if (state == DATA)
                    rsp_sum <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dr_adder_sched.sv
// tb_dr_adder_sched: directed and randomized checks of the dual-rail adder sequencer
module tb_dr_adder_sched;
    localparam int W = 4;
    localparam int S = 2;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic rsp_valid, rsp_id, rsp_err;
    logic rsp_ready = 1'b0;
    logic [W:0] rsp_sum;
    logic [W-1:0] a_1, a_0, b_1, b_0;
    logic [W:0] s_1 = '0, s_0 = '0;
    logic [W:0] msum;
    logic go, adder_reset;
    logic done = 1'b0;
    int checks = 0, errors = 0;
    int mode = 0, lat = 0, dly = 0;
    logic exp_rr = 1'b0;
    logic last_grant = 1'b0;

    always #5 clk = ~clk;

    dr_adder_sched #(.W(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .a_1(a_1), .a_0(a_0), .b_1(b_1), .b_0(b_0),
        .s_1(s_1), .s_0(s_0), .go(go), .done(done), .adder_reset(adder_reset)
    );

    // Adder model: mode 0 ideal, 1 never completes, 2 corrupts bit 2 of the sum rails
    assign msum = {1'b0, a_1} + {1'b0, b_1};
    always @(posedge clk) begin
        if (adder_reset) begin
            done <= 1'b0;
            s_1 <= '0;
            s_0 <= '0;
            dly <= 0;
        end else if (go && !done && mode != 1) begin
            if (dly >= lat) begin
                s_1 <= msum | (mode == 2 ? (W+1)'(4) : (W+1)'(0));
                s_0 <= ~msum | (mode == 2 ? (W+1)'(4) : (W+1)'(0));
                done <= 1'b1;
                dly <= 0;
            end else
                dly <= dly + 1;
        end else if (!go && done) begin
            done <= 1'b0;
            s_1 <= '0;
            s_0 <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction from request to consumed response; called at a negedge with inputs set
    task automatic run_op(input int m, input int hold, input bit keep, input string tag);
        int n;
        int gocnt = 0, arcnt = 0;
        bit rail_bad = 0, rdy_bad = 0, hold_bad = 0;
        logic eg, ee;
        logic [W-1:0] ea, eb;
        logic [W:0] es;
        mode = m;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, " accept"}, n < 30, 1);
        if (n >= 30) return;
        chk({tag, " one ready"}, req0_ready & req1_ready, 0);
        eg = (req0_valid && req1_valid) ? exp_rr : req1_valid;
        chk({tag, " grant"}, req1_ready, eg);
        last_grant = req1_ready;
        exp_rr = !eg;
        ea = eg ? req1_a : req0_a;
        eb = eg ? req1_b : req0_b;
        es = {1'b0, ea} + {1'b0, eb};
        ee = 1'b0;
        if (m == 1) begin
            es = '0;
            ee = 1'b1;
        end else if (m == 2) begin
            es = es | (W+1)'(4);
            ee = 1'b1;
        end
        @(posedge clk);
        #1;
        if (eg) begin
            req1_a = W'($urandom);
            req1_b = W'($urandom);
            if (!keep) req1_valid = 1'b0;
        end else begin
            req0_a = W'($urandom);
            req0_b = W'($urandom);
            if (!keep) req0_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (req0_ready || req1_ready) rdy_bad = 1;
            if (adder_reset) arcnt++;
            if (go) begin
                gocnt++;
                if (a_1 !== ea || a_0 !== ~ea || b_1 !== eb || b_0 !== ~eb) rail_bad = 1;
            end else if ((a_1 | a_0 | b_1 | b_0) !== '0) rail_bad = 1;
        end while (!rsp_valid && n < 100);
        chk({tag, " rsp arrives"}, n < 100, 1);
        if (n >= 100) return;
        if (m != 1) chk({tag, " latency"}, n, 2 * S + 5 + lat);
        chk({tag, " go cycles"}, gocnt, m == 1 ? TO : S + 2 + lat);
        if (m == 1) chk({tag, " adder_reset >=2"}, arcnt >= 2, 1);
        else chk({tag, " adder_reset idle"}, arcnt, 0);
        chk({tag, " rails"}, rail_bad, 0);
        chk({tag, " no ready while busy"}, rdy_bad, 0);
        chk({tag, " rsp_id"}, rsp_id, eg);
        chk({tag, " rsp_sum"}, rsp_sum, es);
        chk({tag, " rsp_err"}, rsp_err, ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== es || rsp_id !== eg || rsp_err !== ee || req0_ready || req1_ready)
                hold_bad = 1;
        end
        if (hold > 0) chk({tag, " hold stable"}, hold_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid drops"}, rsp_valid, 0);
    endtask

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ready", {req0_ready, req1_ready}, 0);
        chk("reset go", go, 0);
        chk("reset rails", {a_1, a_0, b_1, b_0}, 0);
        chk("reset rsp", {rsp_valid, rsp_id, rsp_err, rsp_sum}, 0);
        chk("reset adder_reset", adder_reset, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("adder_reset after reset", adder_reset, 1);
        @(negedge clk);
        chk("adder_reset released", adder_reset, 0);

        lat = 0;
        req0_a = 5; req0_b = 9; req0_valid = 1'b1;
        run_op(0, 0, 0, "5+9");
        req0_a = 15; req0_b = 15; req0_valid = 1'b1;
        run_op(0, 0, 0, "15+15");
        req0_a = 0; req0_b = 0; req0_valid = 1'b1;
        run_op(0, 0, 0, "0+0");

        for (int i = 0; i < 4; i++) begin
            lat = $urandom_range(0, 2);
            if (i % 2 == 0) begin
                req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
            end else begin
                req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
            end
            run_op(0, 0, 0, "random");
        end

        lat = 0;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(0, 0, 1, "both");
            chk("both order", last_grant, i % 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        run_op(1, 0, 0, "timeout");
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        run_op(0, 0, 0, "after timeout");

        req0_valid = 1'b1;
        req1_valid = 1'b1;
        run_op(2, 5, 1, "bad rail");
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        mode = 0;
        @(negedge clk);
        req0_a = 3; req0_b = 4; req0_valid = 1'b1;
        #1;
        chk("mid reset accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("mid reset go before", go, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rr = 1'b0;
        chk("mid reset go", go, 0);
        chk("mid reset rails", {a_1, a_0, b_1, b_0}, 0);
        chk("mid reset rsp_valid", rsp_valid, 0);
        chk("mid reset adder_reset 1", adder_reset, 1);
        @(negedge clk);
        chk("mid reset adder_reset 2", adder_reset, 1);
        @(negedge clk);
        chk("mid reset adder_reset off", adder_reset, 0);
        chk("mid reset no rsp", rsp_valid, 0);
        repeat (2) @(negedge clk);
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        run_op(0, 0, 0, "after reset");
        chk("after reset rr", last_grant, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
